// File: rtl/tpu_pkg.sv
// Shared constants, state encoding and data types for the TPU instruction sequencer.
package tpu_pkg;

    localparam int INSTR_W   = 16;
    localparam int DATA_W    = 16;
    localparam int OPCODE_W  = 3;
    localparam int OPERAND_W = INSTR_W - OPCODE_W;
    localparam int BURST_LEN = 4;

    localparam logic [OPCODE_W-1:0] OP_LOAD_ADDR   = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_LOAD_WEIGHT = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_MATMUL      = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_NOP         = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOADW,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [BURST_LEN-1:0] burst_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LOAD_ADDR) || (op == OP_LOAD_WEIGHT) ||
               (op == OP_MATMUL) || (op == OP_NOP);
    endfunction

endpackage

// File: rtl/tpu_seq_if.sv
// Instruction valid/ready channel and synchronous memory read port of the sequencer.
interface tpu_seq_if
    import tpu_pkg::*;
#(
    parameter int ADDR_W = OPERAND_W
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               mem_ren;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rdata;

    // Host/memory side.
    modport master (
        output instr, instr_valid, mem_rdata,
        input  instr_ready, mem_ren, mem_addr
    );

    // Sequencer side.
    modport slave (
        input  instr, instr_valid, mem_rdata,
        output instr_ready, mem_ren, mem_addr
    );
endinterface

// File: rtl/tpu_seq_fetch.sv
// Four-word burst reader: issues reads start+0..3, collects the returning words.
// The last word is forwarded straight from memory in the fetch_done_o cycle.
module tpu_seq_fetch
    import tpu_pkg::*;
#(
    parameter int ADDR_W = OPERAND_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  word_t             mem_rdata_i,
    output burst_t            words_o,
    output logic              fetch_done_o
);

    localparam logic [2:0] LAST = 3'(BURST_LEN);

    logic                   active_q, active_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]      start_q, start_d;
    word_t [BURST_LEN-2:0]  slots_q, slots_d;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
        slots_d  = slots_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
            start_d  = start_addr_i;
        end else if (active_q) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end
            for (int i = 0; i < BURST_LEN - 1; i++) begin
                if (cnt_q == 3'(i + 1)) slots_d[i] = mem_rdata_i;
            end
        end
    end

    // NOTE: slot registers are reset too, so an aborted burst never leaks stale words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            start_q  <= '0;
            slots_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            active_q <= active_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            slots_q  <= slots_d;
        end
    end

    assign mem_ren_o    = active_q && (cnt_q < LAST);
    assign mem_addr_o   = start_q + ADDR_W'(cnt_q[1:0]);
    assign fetch_done_o = active_q && (cnt_q == LAST);
    assign words_o      = {mem_rdata_i, slots_q};

endmodule

// File: rtl/tpu_sequencer.sv
// Instruction-driven controller for the 2x2 systolic array: weight loads, skewed
// activation streaming and drain. Define TPU_SEQ_ILLEGAL_TRAP_EN for a sticky err flag.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int ADDR_W       = OPERAND_W
) (
    input  logic      clk,
    input  logic      reset,
    tpu_seq_if.slave  bus,
    output logic      load_weight,
    output word_t     weight1,
    output word_t     weight2,
    output word_t     weight3,
    output word_t     weight4,
    output logic      valid,
    output word_t     a_in1,
    output word_t     a_in2,
    output logic      busy,
    output logic      done,
    output logic      err
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 4);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_mm_q, is_mm_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    burst_t                 weights_q, weights_d;
    word_t [BURST_LEN-2:0]  acts_q, acts_d;      // a12, a21, a22 held for the skewed stream
    logic                   load_weight_q, load_weight_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    word_t                  a_in1_q, a_in1_d;
    word_t                  a_in2_q, a_in2_d;

    logic                   accept;
    logic [OPCODE_W-1:0]    opcode;
    logic [ADDR_W-1:0]      operand;
    logic                   fetch_start;
    logic [ADDR_W-1:0]      fetch_addr;
    burst_t                 words;
    logic                   fetch_done;

    assign bus.instr_ready = (state_q == S_IDLE);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign opcode          = bus.instr[INSTR_W-1 -: OPCODE_W];
    assign operand         = bus.instr[ADDR_W-1:0];

    tpu_seq_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk          (clk),
        .reset        (reset),
        .start_i      (fetch_start),
        .start_addr_i (fetch_addr),
        .mem_ren_o    (bus.mem_ren),
        .mem_addr_o   (bus.mem_addr),
        .mem_rdata_i  (bus.mem_rdata),
        .words_o      (words),
        .fetch_done_o (fetch_done)
    );

    // Output registers are loaded with the values the *next* state presents.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_mm_d       = is_mm_q;
        base_d        = base_q;
        weights_d     = weights_q;
        acts_d        = acts_q;
        load_weight_d = 1'b0;
        valid_d       = 1'b0;
        done_d        = 1'b0;
        a_in1_d       = '0;
        a_in2_d       = '0;
        fetch_start   = 1'b0;
        fetch_addr    = base_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_LOAD_ADDR: base_d = operand;
                        OP_LOAD_WEIGHT: begin
                            fetch_start = 1'b1;
                            is_mm_d     = 1'b0;
                            state_d     = S_FETCH;
                        end
                        OP_MATMUL: begin
                            fetch_start = 1'b1;
                            fetch_addr  = operand;
                            is_mm_d     = 1'b1;
                            state_d     = S_FETCH;
                        end
                        default: ;
                    endcase
                end
            end
            S_FETCH: begin
                if (fetch_done) begin
                    if (is_mm_q) begin
                        acts_d  = words[BURST_LEN-1:1];
                        a_in1_d = words[0];
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        weights_d     = words;
                        load_weight_d = 1'b1;
                        state_d       = S_LOADW;
                    end
                end
            end
            S_LOADW: state_d = S_IDLE;
            S_STREAM: begin
                valid_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(0)) begin
                    a_in1_d = acts_q[0];
                    a_in2_d = acts_q[1];
                end else if (cnt_q == CNT_W'(1)) begin
                    a_in2_d = acts_q[2];
                end else begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                valid_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            is_mm_q       <= 1'b0;
            base_q        <= '0;
            weights_q     <= '0;
            acts_q        <= '0;
            load_weight_q <= 1'b0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            a_in1_q       <= '0;
            a_in2_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_mm_q       <= is_mm_d;
            base_q        <= base_d;
            weights_q     <= weights_d;
            acts_q        <= acts_d;
            load_weight_q <= load_weight_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            a_in1_q       <= a_in1_d;
            a_in2_q       <= a_in2_d;
        end
    end

`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
    logic err_q, err_d;

    assign err_d = err_q || (accept && !is_legal_op(opcode));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign load_weight = load_weight_q;
    assign weight1     = weights_q[0];
    assign weight2     = weights_q[1];
    assign weight3     = weights_q[2];
    assign weight4     = weights_q[3];
    assign valid       = valid_q;
    assign a_in1       = a_in1_q;
    assign a_in2       = a_in2_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: stimulus pushes expected reads, weight loads,
// stream beats and done pulses; a negedge monitor pops and compares them.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    typedef struct { int cyc; logic [12:0] addr; } rd_exp_t;
    typedef struct { int cyc; logic [15:0] a1; logic [15:0] a2; } st_exp_t;
    typedef struct { int cyc; logic [63:0] w; } wt_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_weight, valid, busy, done, err;
    logic [15:0] weight1, weight2, weight3, weight4, a_in1, a_in2;
    logic [63:0] w_all;
    logic [15:0] mem [0:8191];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    wt_exp_t lw_q[$];
    wt_exp_t dn_q[$];

    tpu_seq_if #(.ADDR_W(13)) bus ();

    tpu_sequencer #(.DRAIN_CYCLES(4), .ADDR_W(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .load_weight (load_weight),
        .weight1     (weight1),
        .weight2     (weight2),
        .weight3     (weight3),
        .weight4     (weight4),
        .valid       (valid),
        .a_in1       (a_in1),
        .a_in2       (a_in2),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    assign w_all = {weight4, weight3, weight2, weight1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous word memory: data one cycle after the read enable.
    always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    always @(negedge clk) begin : monitor
        rd_exp_t r;
        st_exp_t s;
        wt_exp_t w;
        if (!reset) begin
            if (bus.mem_ren) begin
                if (rd_q.size() == 0) fail_event("read_unexpected", 64'(bus.mem_addr));
                else begin
                    r = rd_q.pop_front();
                    check("read_addr", 64'(bus.mem_addr), 64'(r.addr));
                    check("read_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (load_weight) begin
                if (lw_q.size() == 0) fail_event("load_weight_unexpected", w_all);
                else begin
                    w = lw_q.pop_front();
                    check("lw_weights", w_all, w.w);
                    check("lw_cycle", 64'(cyc), 64'(w.cyc));
                end
            end
            if (valid) begin
                if (st_q.size() == 0) fail_event("valid_unexpected", {32'd0, a_in1, a_in2});
                else begin
                    s = st_q.pop_front();
                    check("stream_a_in1", 64'(a_in1), 64'(s.a1));
                    check("stream_a_in2", 64'(a_in2), 64'(s.a2));
                    check("stream_cycle", 64'(cyc), 64'(s.cyc));
                end
            end
            if (done) begin
                if (dn_q.size() == 0) fail_event("done_unexpected", w_all);
                else begin
                    w = dn_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(w.cyc));
                    check("done_weights", w_all, w.w);
                    check("done_valid_low", 64'(valid), 64'd0);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [12:0] opr, output int c0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) fail_event("ready_timeout", 64'(n));
        bus.instr       = {op, opr};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic push_reads(input int c0, input logic [12:0] start);
        rd_exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = '{c0 + i, start + 13'(i)};
            rd_q.push_back(e);
        end
    endtask

    task automatic push_lw(input int c0, input logic [63:0] w);
        wt_exp_t e;
        e = '{c0 + 5, w};
        lw_q.push_back(e);
    endtask

    task automatic push_matmul(input int c0, input logic [15:0] a11, input logic [15:0] a12,
                               input logic [15:0] a21, input logic [15:0] a22,
                               input logic [63:0] w, input logic full);
        st_exp_t s;
        wt_exp_t d;
        s = '{c0 + 5, a11, 16'd0};
        st_q.push_back(s);
        if (full) begin
            s = '{c0 + 6, a12, a21};
            st_q.push_back(s);
            s = '{c0 + 7, 16'd0, a22};
            st_q.push_back(s);
            for (int k = 0; k < 4; k++) begin
                s = '{c0 + 8 + k, 16'd0, 16'd0};
                st_q.push_back(s);
            end
            d = '{c0 + 12, w};
            dn_q.push_back(d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   c0;
        logic exp_err;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'(i) ^ 16'hC3C3;
        mem[0]      = 16'd3;  mem[1]      = 16'd5;  mem[2]      = 16'd4;  mem[3]      = 16'd6;
        mem[13'h10] = 16'd11; mem[13'h11] = 16'd12; mem[13'h12] = 16'd21; mem[13'h13] = 16'd22;
        mem[13'h20] = 16'd1;  mem[13'h21] = 16'd2;  mem[13'h22] = 16'd3;  mem[13'h23] = 16'd4;
        mem[13'h1FFE] = 16'h0AAA;
        mem[13'h1FFF] = 16'h0BBB;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_instr_ready", 64'(bus.instr_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_load_weight", 64'(load_weight), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_ren", 64'(bus.mem_ren), 64'd0);
        check("rst_a_in", {32'd0, a_in1, a_in2}, 64'd0);
        check("rst_weights", w_all, 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // LOAD_ADDR completes at the accept edge.
        send(OP_LOAD_ADDR, 13'h0000, c0);
        check("la_busy", 64'(busy), 64'd0);
        check("la_ready", 64'(bus.instr_ready), 64'd1);

        send(OP_LOAD_WEIGHT, 13'h0, c0);
        push_reads(c0, 13'h0000);
        push_lw(c0, {16'd6, 16'd4, 16'd5, 16'd3});
        wait_ready("lw_ready_cycle", c0 + 6);
        check("lw_weights_hold", w_all, {16'd6, 16'd4, 16'd5, 16'd3});

        // MATMUL with a LOAD_ADDR offered while busy; it must not be taken.
        send(OP_MATMUL, 13'h0010, c0);
        push_reads(c0, 13'h0010);
        push_matmul(c0, 16'd11, 16'd12, 16'd21, 16'd22, {16'd6, 16'd4, 16'd5, 16'd3}, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mm_ready_low", 64'(bus.instr_ready), 64'd0);
            check("mm_busy", 64'(busy), 64'd1);
            bus.instr       = {OP_LOAD_ADDR, 13'h0500};
            bus.instr_valid = 1'b1;
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        wait_ready("mm_ready_cycle", c0 + 13);
        check("mm_weights_kept", w_all, {16'd6, 16'd4, 16'd5, 16'd3});

        // base_addr still 0: the offered LOAD_ADDR was held off.
        send(OP_LOAD_WEIGHT, 13'h0, c0);
        push_reads(c0, 13'h0000);
        push_lw(c0, {16'd6, 16'd4, 16'd5, 16'd3});
        wait_ready("lw2_ready_cycle", c0 + 6);

        // Address wrap across 0x1FFF.
        send(OP_LOAD_ADDR, 13'h1FFE, c0);
        send(OP_LOAD_WEIGHT, 13'h0, c0);
        push_reads(c0, 13'h1FFE);
        push_lw(c0, {16'd5, 16'd3, 16'h0BBB, 16'h0AAA});
        wait_ready("lw_wrap_ready_cycle", c0 + 6);

        // Reset during STREAM cycle 1.
        send(OP_MATMUL, 13'h0020, c0);
        push_reads(c0, 13'h0020);
        push_matmul(c0, 16'd1, 16'd2, 16'd3, 16'd4, 64'd0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_pre_valid", 64'(valid), 64'd1);
        check("abort_pre_a_in", {32'd0, a_in1, a_in2}, {32'd0, 16'd2, 16'd3});
        reset = 1'b1;
        #1;
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_weights", w_all, 64'd0);
        check("abort_ready", 64'(bus.instr_ready), 64'd1);
        check("abort_queues_empty", 64'(rd_q.size() + st_q.size() + lw_q.size() + dn_q.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        send(OP_MATMUL, 13'h0020, c0);
        push_reads(c0, 13'h0020);
        push_matmul(c0, 16'd1, 16'd2, 16'd3, 16'd4, 64'd0, 1'b1);
        wait_ready("mm2_ready_cycle", c0 + 13);

        // base_addr returned to 0 on reset.
        send(OP_LOAD_WEIGHT, 13'h0, c0);
        push_reads(c0, 13'h0000);
        push_lw(c0, {16'd6, 16'd4, 16'd5, 16'd3});
        wait_ready("lw3_ready_cycle", c0 + 6);

        // Illegal opcode 101.
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("err_before_illegal", 64'(err), 64'd0);
        send(3'b101, 13'h0123, c0);
        check("illegal_ready", 64'(bus.instr_ready), 64'd1);
        check("illegal_err", 64'(err), 64'(exp_err));
        send(OP_NOP, 13'h0, c0);
        check("nop_ready", 64'(bus.instr_ready), 64'd1);
        check("err_sticky", 64'(err), 64'(exp_err));

        repeat (4) @(negedge clk);
        check("left_reads", 64'(rd_q.size()), 64'd0);
        check("left_stream", 64'(st_q.size()), 64'd0);
        check("left_load_weight", 64'(lw_q.size()), 64'd0);
        check("left_done", 64'(dn_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
